// File: rtl/corelet_pkg.sv
// ============================================================================
// corelet_pkg : shared lane geometry, drain FSM states and lane slice helper.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package corelet_pkg;

  localparam int COL     = 8;
  localparam int PSUM_BW = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_RDWAIT = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4
  } drain_state_t;

  function automatic logic [PSUM_BW-1:0] lane_slice(
    input logic [COL*PSUM_BW-1:0] vec,
    input int                     lane
  );
    return vec[lane*PSUM_BW +: PSUM_BW];
  endfunction

endpackage

`default_nettype wire

// File: rtl/psum_drain_lane_add.sv
// ============================================================================
// psum_lane_add : per-lane modulo-2^PSUM_BW add of two psum vectors, with an
//                 optional clamp of negative lanes to zero.
// Revision      : 1.0  initial release
// ============================================================================
`default_nettype none

module psum_lane_add
  import corelet_pkg::*;
(
  input  logic [COL*PSUM_BW-1:0] a,
  input  logic [COL*PSUM_BW-1:0] b,
  input  logic                   relu,
  output logic [COL*PSUM_BW-1:0] y
);

  for (genvar i = 0; i < COL; i++) begin : g_lane
    logic [PSUM_BW-1:0] s;
    assign s = lane_slice(a, i) + lane_slice(b, i);
    assign y[i*PSUM_BW +: PSUM_BW] = (relu && s[PSUM_BW-1]) ? '0 : s;
  end

endmodule

`default_nettype wire

// File: rtl/psum_drain.sv
// ============================================================================
// psum_drain : pops psum vectors from the OFIFO and accumulates them across
//              NUM_KIJ kernel passes into the OP SRAM by read-modify-write.
// Revision   : 1.0  initial release
// ============================================================================
`default_nettype none

module psum_drain
  import corelet_pkg::*;
#(
  parameter int NUM_VEC = 36,
  parameter int NUM_KIJ = 9,
  parameter int ADDR_BW = 9,
  parameter bit RELU_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   ofifo_valid,
  input  logic [COL*PSUM_BW-1:0] ofifo_out,
  output logic                   ofifo_rd,
  input  logic [COL*PSUM_BW-1:0] OP_q,
  output logic [COL*PSUM_BW-1:0] OP_d,
  output logic [ADDR_BW-1:0]     OP_addr,
  output logic                   OP_cen,
  output logic                   OP_wen,
  output logic                   pass_done,
  output logic                   seq_done
);

  localparam int KIJ_BW = (NUM_KIJ > 1) ? $clog2(NUM_KIJ) : 1;
  localparam int VEC_W  = COL * PSUM_BW;

  drain_state_t        state;
  drain_state_t        next_state;
  logic [ADDR_BW-1:0]  vec_cnt;
  logic [KIJ_BW-1:0]   kij_cnt;
  logic [VEC_W-1:0]    vec_reg;
  logic [VEC_W-1:0]    acc_reg;
  logic                pass_done_r;

  logic                last_vec;
  logic                last_kij;
  logic                pass_end;
  logic                relu_now;
  logic [VEC_W-1:0]    sum_vec;
  logic [VEC_W-1:0]    wr_vec;

  assign last_vec = (vec_cnt == ADDR_BW'(NUM_VEC - 1));
  assign last_kij = (kij_cnt == KIJ_BW'(NUM_KIJ - 1));
  assign pass_end = (state == S_WRITE) && last_vec;
  assign relu_now = RELU_EN && last_kij;

  psum_lane_add u_add (
    .a    (OP_q),
    .b    (vec_reg),
    .relu (1'b0),
    .y    (sum_vec)
  );

  // Second instance with a zero addend is used purely as the write-side clamp.
  psum_lane_add u_act (
    .a    (acc_reg),
    .b    ({VEC_W{1'b0}}),
    .relu (relu_now),
    .y    (wr_vec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      vec_cnt     <= '0;
      kij_cnt     <= '0;
      vec_reg     <= '0;
      acc_reg     <= '0;
      pass_done_r <= 1'b0;
    end else begin
      state       <= next_state;
      pass_done_r <= pass_end;
      case (state)
        S_IDLE: begin
          if (start) begin
            vec_cnt <= '0;
            kij_cnt <= '0;
          end
        end
        S_FETCH: begin
          if (ofifo_valid) begin
            vec_reg <= ofifo_out;
            if (kij_cnt == '0) acc_reg <= ofifo_out;
          end
        end
        S_RDWAIT: acc_reg <= sum_vec;
        S_WRITE: begin
          if (last_vec) begin
            vec_cnt <= '0;
            if (!last_kij) kij_cnt <= kij_cnt + 1'b1;
          end else begin
            vec_cnt <= vec_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are decoded combinationally so a reset cycle suppresses them at once.
  always_comb begin
    next_state = state;
    ofifo_rd   = 1'b0;
    OP_cen     = 1'b1;
    OP_wen     = 1'b1;
    OP_addr    = '0;
    OP_d       = '0;
    seq_done   = 1'b0;
    pass_done  = 1'b0;
    if (!reset) begin
      pass_done = pass_done_r;
      case (state)
        S_IDLE: begin
          if (start) next_state = S_FETCH;
        end
        S_FETCH: begin
          if (ofifo_valid) begin
            ofifo_rd = 1'b1;
            if (kij_cnt == '0) begin
              next_state = S_WRITE;
            end else begin
              OP_cen     = 1'b0;
              OP_addr    = vec_cnt;
              next_state = S_RDWAIT;
            end
          end
        end
        S_RDWAIT: next_state = S_WRITE;
        S_WRITE: begin
          OP_cen  = 1'b0;
          OP_wen  = 1'b0;
          OP_addr = vec_cnt;
          OP_d    = wr_vec;
          if (last_vec && last_kij) next_state = S_DONE;
          else                      next_state = S_FETCH;
        end
        S_DONE: begin
          seq_done   = 1'b1;
          next_state = S_IDLE;
        end
        default: next_state = S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_psum_drain.sv
// ============================================================================
// tb_psum_drain : randomized scoreboard bench with OFIFO and OP SRAM models.
// Revision      : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_psum_drain;
  import corelet_pkg::*;

  localparam int NV = 4;
  localparam int NK = 3;
  localparam int AB = 9;
  localparam int W  = COL * PSUM_BW;

  typedef logic [W-1:0] vec_t;
  typedef struct {
    logic [AB-1:0] a;
    vec_t          d;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset, start, ofifo_valid;
  vec_t          ofifo_out, OP_q, OP_d;
  logic [AB-1:0] OP_addr;
  logic          ofifo_rd, OP_cen, OP_wen, pass_done, seq_done;

  always #5 clk = ~clk;

  psum_drain #(
    .NUM_VEC (NV),
    .NUM_KIJ (NK),
    .ADDR_BW (AB),
    .RELU_EN (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ofifo_valid (ofifo_valid),
    .ofifo_out   (ofifo_out),
    .ofifo_rd    (ofifo_rd),
    .OP_q        (OP_q),
    .OP_d        (OP_d),
    .OP_addr     (OP_addr),
    .OP_cen      (OP_cen),
    .OP_wen      (OP_wen),
    .pass_done   (pass_done),
    .seq_done    (seq_done)
  );

  int   n_chk  = 0;
  int   n_pass = 0;
  vec_t fifo_q[$];
  wr_t  exp_q[$];
  vec_t mem [0:(1<<AB)-1];
  int   pops = 0, reads = 0, writes = 0, passes = 0, seqs = 0;

  task automatic check(input string name, input vec_t act, input vec_t exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Environment: OFIFO source, OP SRAM model and output monitor.
  initial begin : monitor
    logic          rd_now, cen_now, wen_now, prev_final;
    logic [AB-1:0] addr_now;
    vec_t          d_now;
    wr_t           e;
    ofifo_valid = 1'b0;
    ofifo_out   = '0;
    OP_q        = '0;
    prev_final  = 1'b0;
    forever begin
      @(negedge clk);
      rd_now   = ofifo_rd;
      cen_now  = OP_cen;
      wen_now  = OP_wen;
      addr_now = OP_addr;
      d_now    = OP_d;
      if (!reset) begin
        if (rd_now) begin
          check("rd_only_when_valid", ofifo_valid, 1);
          pops++;
        end
        if (!cen_now && wen_now) begin
          reads++;
          if (exp_q.size() > 0) check("rd_addr", addr_now, exp_q[0].a);
          else check("rd_unexpected", 0, 1);
        end
        if (!cen_now && !wen_now) begin
          writes++;
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wr_addr", addr_now, e.a);
            check("wr_data", d_now, e.d);
          end else check("wr_unexpected", 0, 1);
        end
        if (pass_done || prev_final) check("pass_done_timing", pass_done, prev_final);
        if (pass_done) passes++;
        if (seq_done) seqs++;
        prev_final = !cen_now && !wen_now && (addr_now == AB'(NV - 1));
      end else begin
        prev_final = 1'b0;
      end
      @(posedge clk);
      #1;
      if (rd_now && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (!cen_now && wen_now)  OP_q = mem[addr_now];
      if (!cen_now && !wen_now) mem[addr_now] = d_now;
      ofifo_valid = (fifo_q.size() > 0) && ($urandom_range(0, 3) != 0);
      ofifo_out   = (fifo_q.size() > 0) ? fifo_q[0] : vec_t'({$urandom, $urandom, $urandom, $urandom});
    end
  end

  // Reference model: plain per-lane arithmetic over the whole sequence.
  task automatic load_seq(input bit directed);
    int   lanes [NK][NV][COL];
    int   acc   [NV][COL];
    vec_t v;
    wr_t  w;
    for (int k = 0; k < NK; k++)
      for (int n = 0; n < NV; n++)
        for (int i = 0; i < COL; i++)
          lanes[k][n][i] = int'($urandom_range(0, 65535));
    if (directed) begin
      lanes[0][0][0] = 'h7FFF; lanes[1][0][0] = 'h0001; lanes[2][0][0] = 'h0000;
      lanes[0][1][1] = 'hFFFC; lanes[1][1][1] = 'hFFFD; lanes[2][1][1] = 'h0000;
      lanes[0][1][2] = 3;      lanes[1][1][2] = 4;      lanes[2][1][2] = 0;
    end
    for (int k = 0; k < NK; k++) begin
      for (int n = 0; n < NV; n++) begin
        for (int i = 0; i < COL; i++) begin
          acc[n][i] = (k == 0) ? lanes[k][n][i] : (acc[n][i] + lanes[k][n][i]) % 65536;
          v[i*PSUM_BW +: PSUM_BW] = 16'(lanes[k][n][i]);
          w.d[i*PSUM_BW +: PSUM_BW] = (k == NK - 1 && acc[n][i] >= 32768) ? 16'd0 : 16'(acc[n][i]);
        end
        w.a = AB'(n);
        fifo_q.push_back(v);
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic flush_with_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    fifo_q.delete();
    exp_q.delete();
  endtask

  task automatic run_seq(input bit directed, input bit abort, input bit poke_start);
    int b_pops, b_reads, b_passes, b_seqs, t;
    load_seq(directed);
    b_pops = pops; b_reads = reads; b_passes = passes; b_seqs = seqs;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    t = 0;
    if (abort) begin
      while (reads < b_reads + 2 && t < 500) begin @(posedge clk); t++; end
      if (t >= 500) begin check("abort_timeout", 0, 1); flush_with_reset(); return; end
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("midrst_cen", OP_cen, 1);
      check("midrst_wen", OP_wen, 1);
      check("midrst_rd", ofifo_rd, 0);
      check("midrst_d", OP_d, 0);
      check("midrst_pass_done", pass_done, 0);
      @(posedge clk); #1 reset = 1'b0;
      fifo_q.delete();
      exp_q.delete();
      return;
    end
    while (seqs == b_seqs && t < 2000) begin
      @(posedge clk); t++;
      if (poke_start) start = (t == 7 || t == 20);
    end
    #1 start = 1'b0;
    if (t >= 2000) begin check("seq_timeout", 0, 1); flush_with_reset(); return; end
    repeat (4) @(posedge clk);
    check("pops", pops - b_pops, NV * NK);
    check("sram_reads", reads - b_reads, NV * (NK - 1));
    check("pass_done_count", passes - b_passes, NK);
    check("seq_done_count", seqs - b_seqs, 1);
    check("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin : stimulus
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd", ofifo_rd, 0);
    check("rst_cen", OP_cen, 1);
    check("rst_wen", OP_wen, 1);
    check("rst_addr", OP_addr, 0);
    check("rst_d", OP_d, 0);
    check("rst_pass_done", pass_done, 0);
    check("rst_seq_done", seq_done, 0);
    @(posedge clk); #1 reset = 1'b0;
    run_seq(1'b1, 1'b0, 1'b0);
    run_seq(1'b0, 1'b0, 1'b1);
    run_seq(1'b0, 1'b1, 1'b0);
    run_seq(1'b0, 1'b0, 1'b0);
    run_seq(1'b1, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
